frame_char_tx: RTL

- Character-stream transmitter. It serializes one formatted record (format type plus 16-bit freq value) into a sequence of 8-bit ASCII chars, one per handshake.
- Output is the stream consumed by the char/freq format checker. That checker recovers format_type and reports error_code.
- Sits between the test-stimulus control logic and the checker; also used as the loopback source in checker benches.

---
 rtl/frame_char_tx_pkg.sv | 46 ++++
 rtl/frame_char_tx_if.sv | 42 ++++
 rtl/frame_char_tx_nibble_to_hex.sv | 23 ++
 rtl/frame_char_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/frame_char_tx_pkg.sv
// ---------------------------------------------------------------------------
// frame_char_tx_pkg
// Shared definitions for the frame character transmitter and the matching
// char/freq format checker.
//
// Contents:
//   - default frame delimiters and type-character base
//   - reserved format code and digit counts
//   - state enum plus plain 3-bit state constants
//
// Optional feature macro used by the users of this package:
//   FRAME_TX_CHECKSUM_EN
// ---------------------------------------------------------------------------
package frame_char_tx_pkg;

  // Frame delimiters and the base char that the format type is added to.
  localparam logic [7:0] HEAD_CHAR_DEFAULT = 8'h7B;  // '{'
  localparam logic [7:0] TAIL_CHAR_DEFAULT = 8'h7D;  // '}'
  localparam logic [7:0] TYPE_BASE_DEFAULT = 8'h41;  // 'A'

  // Format code 2'b11 is reserved and never framed.
  localparam logic [1:0] FMT_INVALID = 2'b11;

  // Payload is four hex digits; the optional checksum adds two more.
  localparam int HEX_DIGITS  = 4;
  localparam int CSUM_DIGITS = 2;

  // Frame states, in emission order.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_TYPE = 3'd2,
    S_DIG  = 3'd3,
    S_CSUM = 3'd4,
    S_TAIL = 3'd5
  } tx_state_e;

  // Plain vector constants for state registers that must stay enum-free.
  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_HEAD = S_HEAD;
  localparam logic [2:0] ST_TYPE = S_TYPE;
  localparam logic [2:0] ST_DIG  = S_DIG;
  localparam logic [2:0] ST_CSUM = S_CSUM;
  localparam logic [2:0] ST_TAIL = S_TAIL;

endpackage

// File: rtl/frame_char_tx_if.sv
// ---------------------------------------------------------------------------
// frame_char_tx_if
// Request and character-stream signals of the frame transmitter.
//
// Signals:
//   start        request to send one frame
//   format_type  record type (2'b11 reserved)
//   freq         16-bit payload value
//   ready        downstream accepts the current char
//   char         current ASCII char
//   valid        char is valid
//   busy         frame in progress
//   done         one-cycle pulse after the tail char transfer
//   bad_fmt      one-cycle pulse when a start is rejected
//
// Modports:
//   master  the transmitter itself (drives the char stream and status)
//   slave   the stimulus/consumer side (drives the request and ready)
// ---------------------------------------------------------------------------
interface frame_char_tx_if;

  logic        start;
  logic [1:0]  format_type;
  logic [15:0] freq;
  logic        ready;
  logic [7:0]  char;
  logic        valid;
  logic        busy;
  logic        done;
  logic        bad_fmt;

  modport master (
    input  start, format_type, freq, ready,
    output char, valid, busy, done, bad_fmt
  );

  modport slave (
    output start, format_type, freq, ready,
    input  char, valid, busy, done, bad_fmt
  );

endinterface

// File: rtl/frame_char_tx_nibble_to_hex.sv
// ---------------------------------------------------------------------------
// frame_char_tx_nibble_to_hex
// Combinational 4-bit to uppercase ASCII hex digit converter.
//
// Ports:
//   nibble  in   4  value 0..15
//   ascii   out  8  '0'..'9' or 'A'..'F'
// ---------------------------------------------------------------------------
module frame_char_tx_nibble_to_hex (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits map onto '0'..'9'; letters start at 'A' for value ten.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h41 + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/frame_char_tx.sv
// ---------------------------------------------------------------------------
// frame_char_tx
// Serializes one record (format type + 16-bit freq) into an ASCII char
// stream with a valid/ready handshake:
//   HEAD, TYPE_BASE+format_type, 4 hex digits of freq (MSB first),
//   [2 hex checksum digits], TAIL
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    frame_char_tx_if.master (start/format_type/freq/ready in,
//          char/valid/busy/done/bad_fmt out)
//
// Macro FRAME_TX_CHECKSUM_EN: when defined, two hex digits of the XOR of
// the type char and the four freq digit chars are sent before the tail.
// ---------------------------------------------------------------------------
module frame_char_tx
  import frame_char_tx_pkg::*;
#(
  parameter logic [7:0] HEAD_CHAR = HEAD_CHAR_DEFAULT,
  parameter logic [7:0] TAIL_CHAR = TAIL_CHAR_DEFAULT,
  parameter logic [7:0] TYPE_BASE = TYPE_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  frame_char_tx_if.master bus
);

  localparam logic [1:0] DIG_LAST = 2'(HEX_DIGITS - 1);

`ifdef FRAME_TX_CHECKSUM_EN
  localparam logic       CSUM_LAST    = 1'(CSUM_DIGITS - 1);
  localparam logic [2:0] ST_AFTER_DIG = ST_CSUM;
`else
  localparam logic [2:0] ST_AFTER_DIG = ST_TAIL;
`endif

  logic [2:0]  state;
  logic [1:0]  dig_cnt;
  logic [1:0]  fmt_q;
  logic [15:0] freq_q;
  logic        done_q;
  logic        bad_fmt_q;

`ifdef FRAME_TX_CHECKSUM_EN
  logic        csum_cnt;
  logic [7:0]  csum_q;
`endif

  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  type_char;
  logic [7:0]  char_d;
  logic        valid_d;
  logic        xfer;

  // Only one hex converter: the freq digits and checksum digits are never
  // on the wire at the same time, so the nibble is picked by state.
  always_comb begin
    nibble = 4'h0;
    if (state == ST_DIG) begin
      case (dig_cnt)
        2'd0:    nibble = freq_q[15:12];
        2'd1:    nibble = freq_q[11:8];
        2'd2:    nibble = freq_q[7:4];
        default: nibble = freq_q[3:0];
      endcase
    end
`ifdef FRAME_TX_CHECKSUM_EN
    else if (state == ST_CSUM) begin
      nibble = csum_cnt ? csum_q[3:0] : csum_q[7:4];
    end
`endif
  end

  frame_char_tx_nibble_to_hex u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  assign type_char = TYPE_BASE + {6'b0, fmt_q};

  // Output char is a pure function of registered state, so it cannot move
  // while the consumer holds ready low.
  always_comb begin
    char_d = 8'h00;
    case (state)
      ST_HEAD: char_d = HEAD_CHAR;
      ST_TYPE: char_d = type_char;
      ST_DIG,
      ST_CSUM: char_d = hex_char;
      ST_TAIL: char_d = TAIL_CHAR;
      default: char_d = 8'h00;
    endcase
  end

  assign valid_d = (state != ST_IDLE);
  assign xfer    = valid_d && bus.ready;

  assign bus.char    = char_d;
  assign bus.valid   = valid_d;
  assign bus.busy    = valid_d;
  assign bus.done    = done_q;
  assign bus.bad_fmt = bad_fmt_q;

  // Frame sequencer. Each char advances only on its own transfer; the
  // done and bad_fmt pulses default low every cycle. Leaving TAIL lands in
  // IDLE together with done, so a start in the done cycle is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dig_cnt   <= 2'd0;
      fmt_q     <= 2'd0;
      freq_q    <= 16'h0000;
      done_q    <= 1'b0;
      bad_fmt_q <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
      csum_cnt  <= 1'b0;
      csum_q    <= 8'h00;
`endif
    end else begin
      done_q    <= 1'b0;
      bad_fmt_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.format_type == FMT_INVALID) begin
              bad_fmt_q <= 1'b1;
            end else begin
              fmt_q   <= bus.format_type;
              freq_q  <= bus.freq;
              dig_cnt <= 2'd0;
`ifdef FRAME_TX_CHECKSUM_EN
              csum_cnt <= 1'b0;
              csum_q   <= 8'h00;
`endif
              state   <= ST_HEAD;
            end
          end
        end
        ST_HEAD: begin
          if (xfer) state <= ST_TYPE;
        end
        ST_TYPE: begin
          if (xfer) begin
`ifdef FRAME_TX_CHECKSUM_EN
            csum_q <= csum_q ^ type_char;
`endif
            state <= ST_DIG;
          end
        end
        ST_DIG: begin
          if (xfer) begin
`ifdef FRAME_TX_CHECKSUM_EN
            csum_q <= csum_q ^ hex_char;
`endif
            if (dig_cnt == DIG_LAST) begin
              state <= ST_AFTER_DIG;
            end else begin
              dig_cnt <= dig_cnt + 2'd1;
            end
          end
        end
`ifdef FRAME_TX_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            if (csum_cnt == CSUM_LAST) begin
              state <= ST_TAIL;
            end else begin
              csum_cnt <= csum_cnt + 1'b1;
            end
          end
        end
`endif
        ST_TAIL: begin
          if (xfer) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
